// File: rtl/fir4_pkg.sv
// fir4_pkg: shared constants, FSM state type and width helpers for fir4_inverse
package fir4_pkg;
  localparam int TAPS = 4;
  typedef enum logic {RUN, ERR} state_t;
  function automatic int sum_w(int w);
    return w + 2;
  endfunction
  function automatic int dif_w(int w);
    return w + 3;
  endfunction
endpackage

// File: rtl/fir4_inverse_if.sv
// fir4_inverse_if: valid-qualified sum stream in, recovered sample stream and status out
interface fir4_inverse_if import fir4_pkg::*; #(parameter int w = 16);
  logic [sum_w(w)-1:0] s_in;
  logic s_valid;
  logic [w-1:0] a_out;
  logic a_valid;
  logic primed;
  logic err;
  modport master (output s_in, s_valid, input a_out, a_valid, primed, err);
  modport slave (input s_in, s_valid, output a_out, a_valid, primed, err);
endinterface

// File: rtl/rca_addsub.sv
// rca_addsub: bit-level ripple-carry add/subtract of signed operands, result one bit wider
module rca_addsub #(parameter int n = 8) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sub,
  output logic [n:0]   s
);
  logic [n:0] c;
  logic [n-1:0] bx;
  assign bx = b ^ {n{sub}};
  assign c[0] = sub;
  for (genvar i = 0; i < n; i++) begin : g_bit
    assign s[i] = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  // top bit is the true sign of the sign-extended sum, so the result never wraps
  assign s[n] = a[n-1] ^ bx[n-1] ^ c[n];
endmodule

// File: rtl/fir4_inverse.sv
// fir4_inverse: recovers x[n] = y[n] - y[n-1] + x[n-4] from a 4-tap all-ones FIR output
module fir4_inverse import fir4_pkg::*; #(parameter int w = 16) (
  input logic clk,
  input logic reset,
  fir4_inverse_if.slave bus
);
  localparam int SW = sum_w(w);
  localparam int DW = dif_w(w);
  state_t state_q, state_d;
  logic [SW-1:0] y_prev_q, y_prev_d;
  logic [w-1:0] hist_q [TAPS];
  logic [w-1:0] hist_d [TAPS];
  logic [1:0] cnt_q, cnt_d;
  logic primed_q, primed_d;
  logic [w-1:0] a_out_q, a_out_d;
  logic a_valid_q, a_valid_d;
  logic [DW:0] d;
  logic [DW+1:0] r;
  logic acc, ok;
  rca_addsub #(.n(DW)) u_sub (
    .a({1'b0, bus.s_in}), .b({1'b0, y_prev_q}), .sub(1'b1), .s(d)
  );
  rca_addsub #(.n(DW+1)) u_add (
    .a(d), .b({{(DW+1-w){1'b0}}, hist_q[TAPS-1]}), .sub(1'b0), .s(r)
  );
  assign acc = bus.s_valid && state_q == RUN;
  assign ok = r[DW+1:w] == '0;
  always_comb begin
    state_d = state_q;
    y_prev_d = y_prev_q;
    hist_d = hist_q;
    cnt_d = cnt_q;
    primed_d = primed_q;
    a_out_d = a_out_q;
    a_valid_d = 1'b0;
    if (acc && ok) begin
      a_out_d = r[w-1:0];
      a_valid_d = 1'b1;
      y_prev_d = bus.s_in;
      for (int k = TAPS - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
      hist_d[0] = r[w-1:0];
      cnt_d = cnt_q == 2'd3 ? 2'd3 : cnt_q + 2'd1;
      primed_d = primed_q | (cnt_q == 2'd3);
    end else if (acc) begin
      state_d = ERR;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      y_prev_q <= '0;
      hist_q <= '{default: '0};
      cnt_q <= '0;
      primed_q <= 1'b0;
      a_out_q <= '0;
      a_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_prev_q <= y_prev_d;
      hist_q <= hist_d;
      cnt_q <= cnt_d;
      primed_q <= primed_d;
      a_out_q <= a_out_d;
      a_valid_q <= a_valid_d;
    end
  end
  assign bus.a_out = a_out_q;
  assign bus.a_valid = a_valid_q;
  assign bus.primed = primed_q;
  assign bus.err = state_q == ERR;
endmodule

// File: tb/tb_fir4_inverse.sv
// tb_fir4_inverse: scoreboard bench driving a golden 4-tap sum model into fir4_inverse
module tb_fir4_inverse;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  fir4_inverse_if #(.w(W)) bus ();
  fir4_inverse #(.w(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_val = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] last_out = '0;
  logic [W-1:0] x1 = '0, x2 = '0, x3 = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [W+1:0] s, input logic push, input logic [W-1:0] e);
    bus.s_valid = v;
    bus.s_in = s;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    check("a_valid", 32'(bus.a_valid), 32'(push));
    if (bus.a_valid) begin
      n_val++;
      if (sb.size() > 0) begin
        last_out = sb.pop_front();
        check("a_out", 32'(bus.a_out), 32'(last_out));
      end else check("sb_empty", 32'd1, 32'd0);
    end else check("a_out_hold", 32'(bus.a_out), 32'(last_out));
  endtask
  task automatic do_reset(input logic v, input logic [W+1:0] s);
    reset = 1'b0;
    bus.s_valid = v;
    bus.s_in = s;
    @(posedge clk);
    #1;
    check("rst_a_out", 32'(bus.a_out), 32'd0);
    check("rst_a_valid", 32'(bus.a_valid), 32'd0);
    check("rst_primed", 32'(bus.primed), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;
    bus.s_valid = 1'b0;
    sb.delete();
    last_out = '0;
    x1 = '0; x2 = '0; x3 = '0;
    n_acc = 0;
    n_val = 0;
  endtask
  task automatic send_x(input logic [W-1:0] x);
    logic [W+1:0] s;
    s = 18'(x) + 18'(x1) + 18'(x2) + 18'(x3);
    step(1'b1, s, 1'b1, x);
    x3 = x2; x2 = x1; x1 = x;
    n_acc++;
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_in = '0;
    do_reset(1'b0, '0);
    // impulse
    step(1'b1, 18'd5, 1'b1, 16'd5);
    step(1'b1, 18'd5, 1'b1, 16'd0);
    step(1'b1, 18'd5, 1'b1, 16'd0);
    check("imp_primed_3", 32'(bus.primed), 32'd0);
    step(1'b1, 18'd5, 1'b1, 16'd0);
    check("imp_primed_4", 32'(bus.primed), 32'd1);
    step(1'b1, 18'd0, 1'b1, 16'd0);
    step(1'b1, 18'd0, 1'b1, 16'd0);
    check("imp_err", 32'(bus.err), 32'd0);
    check("imp_drain", 32'(sb.size()), 32'd0);
    // full scale
    do_reset(1'b0, '0);
    for (int i = 0; i < 5; i++) send_x(16'hffff);
    check("fs_err", 32'(bus.err), 32'd0);
    check("fs_primed", 32'(bus.primed), 32'd1);
    check("fs_drain", 32'(sb.size()), 32'd0);
    // random loopback with gaps
    do_reset(1'b0, '0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) < 30) step(1'b0, 18'($urandom), 1'b0, '0);
      else send_x(16'($urandom_range(0, 65535)));
    end
    check("rnd_count", 32'(n_val), 32'(n_acc));
    check("rnd_err", 32'(bus.err), 32'd0);
    check("rnd_primed", 32'(bus.primed), 32'd1);
    check("rnd_drain", 32'(sb.size()), 32'd0);
    // underflow
    do_reset(1'b0, '0);
    step(1'b1, 18'd1, 1'b1, 16'd1);
    check("uf_err0", 32'(bus.err), 32'd0);
    step(1'b1, 18'd0, 1'b0, '0);
    check("uf_err1", 32'(bus.err), 32'd1);
    step(1'b1, 18'd7, 1'b0, '0);
    check("uf_err_sticky", 32'(bus.err), 32'd1);
    // overflow on first sample
    do_reset(1'b0, '0);
    step(1'b1, 18'd70000, 1'b0, '0);
    check("of_err", 32'(bus.err), 32'd1);
    step(1'b1, 18'd0, 1'b0, '0);
    check("of_primed", 32'(bus.primed), 32'd0);
    // reset mid-stream with a concurrent valid sample that must be discarded
    do_reset(1'b0, '0);
    step(1'b1, 18'd3, 1'b1, 16'd3);
    step(1'b1, 18'd3, 1'b1, 16'd0);
    do_reset(1'b1, 18'd50);
    step(1'b1, 18'd9, 1'b1, 16'd9);
    step(1'b1, 18'd9, 1'b1, 16'd0);
    check("mr_err", 32'(bus.err), 32'd0);
    check("mr_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir4_inverse.md
Name: fir4_inverse

Overview:
- Recovers the original sample stream from the output of the 4-tap all-ones FIR, where y[n] = x[n]+x[n-1]+x[n-2]+x[n-3].
- Recursion: x[n] = y[n] - y[n-1] + x[n-4].
- Sits on the receive/check side of the filter path. Used for loopback self-test, and to detect corrupted or misaligned filter output.
- Valid-qualified stream in, valid-qualified stream out. Sticky error FSM.

Parameters:
- w, 16, recovered sample width. The input sum width is w+2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk).
- s_in  input  w+2  FIR output sample, unsigned.
- s_valid  input  1  s_in is valid this cycle. There is no backpressure; the block always accepts.
- a_out  output  w  recovered sample, unsigned.
- a_valid  output  1  a_out is valid this cycle.
- primed  output  1  at least 4 samples accepted since reset, so the history holds only real data.
- err  output  1  sticky: a recovered value fell outside [0, 2^w-1].

Behaviour:
- Reset (reset==0 at posedge):
  - y_prev=0, hist[1..4]=0, fill count=0, state=RUN.
  - a_out=0, a_valid=0, primed=0, err=0.
  - Reset has priority over every other event, including mid-stream.
- Zero history at reset matches the filter's own reset-to-zero, so the first sample needs no special case.
- Datapath for an accepted sample (s_valid==1 and state==RUN):
  - d = s_in - y_prev, computed in w+3 bits signed.
  - r = d + zero-extend(hist[4]), computed in w+3 bits signed.
  - Both operations use ripple-carry add/subtract built from the rca_addsub sub-module, two instances.
- Range check:
  - In range means r >= 0 and r <= 2^w-1.
  - If in range: the next posedge sets a_out=r[w-1:0] and a_valid=1. History shifts: hist[4]<=hist[3], hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=r[w-1:0]. Also y_prev<=s_in.
  - If out of range: the next posedge sets err=1, state=ERR, a_valid=0. a_out, history and y_prev hold.
- Latency: exactly 1 cycle from accepted s_in to a_out/a_valid.
- Throughput: one sample per cycle.
- On a cycle with s_valid==0: a_valid=0 next cycle, a_out holds its last value, and all state holds. Gaps are transparent to the recursion.
- Fill counter:
  - 2-bit, increments on each in-range accepted sample and saturates at 3.
  - primed goes 1 on the posedge that accepts the 4th sample. It stays 1 until reset.
- FSM has two states:
  - RUN → ERR on an out-of-range result.
  - ERR → RUN only via reset.
  - In ERR, inputs are ignored, a_valid=0 and err=1.
- Wrap-around: no modular arithmetic is allowed. The full w+3 bit result is checked, so any underflow or overflow is flagged and never truncated.
- Worst-case magnitudes:
  - s_in ≤ 4(2^w-1).
  - d lies within ±4(2^w-1), which fits in w+3 bits signed.

Decomposition:
- Package fir4_pkg holds:
  - localparam TAPS=4.
  - typedef state_t {RUN, ERR}.
  - Width constants for the sum width (w+2) and difference width (w+3), expressed as functions of w.
- One sub-module, rca_addsub:
  - Parameterised width, inputs a, b and sub.
  - Output is a sum one bit wider.
  - Bit-level ripple carry; subtraction is done by inverting b with carry-in 1.
- Top level holds the registers, fill counter, FSM and range check. The top-level target is about 150–250 lines.

Test Plan:
- Impulse, w=16: s_in stream 5,5,5,5,0,0 with s_valid=1 → a_out 5,0,0,0,0,0, each 1 cycle later. primed rises after the 4th sample; err=0.
- Full-scale: drive the FIR model with x=65535 constant, giving s_in 65535,131070,196605,262140,262140 → a_out all 65535; no err.
- Random loopback: 1000 random x through a golden 4-tap sum model, with s_valid randomly deasserted 30% of the time → a_out sequence equals x exactly, a_valid count equals accepted count, and a_out holds during gaps.
- Underflow: s_in 1 then 0 → a_out 1, then err=1 and a_valid=0. A subsequent s_in 7 is ignored, and err stays 1.
- Overflow: s_in 70000 as the first sample → r=70000 > 65535, so err=1, a_valid never asserts, y_prev stays 0.
- Reset mid-stream: reset=0 for one cycle after 2 samples, concurrent with s_valid=1 → all outputs 0 next cycle and that input is discarded. The stream restarts cleanly, with s_in 9,9 → a_out 9,0.
